// File: rtl/disp_arb_pkg.sv
// Shared types and constants for the display arbiter.
package disp_arb_pkg;

  localparam int N_REQ = 3;

  localparam int REQ_CPU = 0;
  localparam int REQ_PC  = 1;
  localparam int REQ_SW  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } arb_state_e;

  typedef logic [1:0] req_idx_t;

  // Successor of a requester index, wrapping at N_REQ.
  function automatic req_idx_t next_idx(input req_idx_t i);
    return (i == req_idx_t'(N_REQ - 1)) ? req_idx_t'(0) : req_idx_t'(i + 2'd1);
  endfunction

endpackage

// File: rtl/disp_rr_pick.sv
// Combinational round-robin picker: first set, non-excluded request
// found scanning from ptr upward (mod N_REQ).
module disp_rr_pick
  import disp_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  req_idx_t         ptr,
  input  logic [N_REQ-1:0] excl,
  output req_idx_t         winner,
  output logic             valid
);

  logic [N_REQ-1:0] cand;
  req_idx_t         idx;

  // Scan candidates in round-robin order and keep the first hit.
  always_comb begin
    cand   = req & ~excl;
    winner = '0;
    valid  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!valid && cand[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
      idx = next_idx(idx);
    end
  end

endmodule

// File: rtl/disp_arbiter.sv
// Display arbiter: three requesters share one tube driver word.
// A grant is held for at least HOLD_CYCLES before a competitor may
// preempt it; the owner can release at any time by dropping req.
// Optional blinking of selected digits is enabled with DISP_BLINK_EN.
//
// state | meaning
// IDLE  | no owner, waiting for any request
// GRANT | owner within its minimum tenure, cannot be preempted
// HOLD  | tenure served, competitor requests take over
module disp_arbiter
  import disp_arb_pkg::*;
#(
  parameter int HOLD_CYCLES = 100000000,
  parameter int BLINK_HALF  = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] upd,
  input  logic [31:0]      data0,
  input  logic [31:0]      data1,
  input  logic [31:0]      data2,
  input  logic [7:0]       blink_mask,
  output logic [N_REQ-1:0] gnt,
  output logic [31:0]      show_data,
  output logic [7:0]       blank,
  output logic             busy
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  arb_state_e       state_q, state_d;
  req_idx_t         ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [31:0]      show_q, show_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic             busy_q;

  req_idx_t         owner_idx;
  logic             owner_req;
  logic             owner_upd;
  req_idx_t         pick_win;
  logic             pick_valid;

  function automatic logic [31:0] sel_data(input req_idx_t i, input logic [31:0] d0,
                                           input logic [31:0] d1, input logic [31:0] d2);
    case (i)
      req_idx_t'(REQ_CPU): return d0;
      req_idx_t'(REQ_PC):  return d1;
      default:             return d2;
    endcase
  endfunction

  // The current owner is excluded, so in HOLD the pick is a competitor;
  // in IDLE gnt is zero and nothing is excluded.
  disp_rr_pick u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .excl   (gnt_q),
    .winner (pick_win),
    .valid  (pick_valid)
  );

  // Decode the owner index and its req/upd from the one-hot grant.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) owner_idx = req_idx_t'(i);
    end
    owner_req = |(req & gnt_q);
    owner_upd = |(upd & gnt_q);
  end

  // Next-state, grant, displayed word and tenure counter.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    show_d     = show_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = GRANT;
          gnt_d      = {{(N_REQ-1){1'b0}}, 1'b1} << pick_win;
          show_d     = sel_data(pick_win, data0, data1, data2);
          hold_cnt_d = '0;
          ptr_d      = next_idx(pick_win);
        end
      end
      GRANT, HOLD: begin
        if (!owner_req) begin
          // Release: word stays on the display, a final update still lands.
          state_d    = IDLE;
          gnt_d      = '0;
          hold_cnt_d = '0;
          if (owner_upd) show_d = sel_data(owner_idx, data0, data1, data2);
        end else if (state_q == HOLD && pick_valid) begin
          // Handover: the new owner's word wins over any owner update.
          state_d    = GRANT;
          gnt_d      = {{(N_REQ-1){1'b0}}, 1'b1} << pick_win;
          show_d     = sel_data(pick_win, data0, data1, data2);
          hold_cnt_d = '0;
          ptr_d      = next_idx(pick_win);
        end else begin
          if (owner_upd) show_d = sel_data(owner_idx, data0, data1, data2);
          if (state_q == GRANT) begin
            if (hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + 1'b1;
            if (hold_cnt_d == HOLD_LAST) state_d = HOLD;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      show_q     <= '0;
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      show_q     <= show_d;
      hold_cnt_q <= hold_cnt_d;
      busy_q     <= |gnt_d;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] blink_cnt_q;
  logic          phase_q;

  // Blink phase toggles every BLINK_HALF busy cycles, restarting on any grant change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (gnt_d != gnt_q) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (busy_q) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign blank = blink_mask & {8{phase_q}};
`else
  logic unused_blink;
  assign unused_blink = ^{blink_mask, 1'(BLINK_HALF)};
  assign blank        = 8'h00;
`endif

  assign gnt       = gnt_q;
  assign show_data = show_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter: directed scenarios followed by
// random traffic, all compared against a behavioural model.
module tb_disp_arbiter;

  localparam int HOLD = 4;
  localparam int BH   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, upd;
  logic [31:0] data0, data1, data2;
  logic [7:0]  blink_mask;
  logic [2:0]  gnt;
  logic [31:0] show_data;
  logic [7:0]  blank;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state: owner (-1 idle), cycles held, rr pointer,
  // displayed word, cycles since last grant change.
  int          m_owner = -1;
  int          m_ten   = 0;
  int          m_ptr   = 0;
  logic [31:0] m_show  = '0;
  int          m_since = 0;

  always #5 clk = ~clk;

  disp_arbiter #(.HOLD_CYCLES(HOLD), .BLINK_HALF(BH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .upd        (upd),
    .data0      (data0),
    .data1      (data1),
    .data2      (data2),
    .blink_mask (blink_mask),
    .gnt        (gnt),
    .show_data  (show_data),
    .blank      (blank),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [2:0] rq, input int ptr, input int excl);
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (ptr + k) % 3;
      if (rq[i] && i != excl) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] pick_word(input int i, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] c);
    return (i == 0) ? a : (i == 1) ? b : c;
  endfunction

  task automatic model_step(input logic r, input logic [2:0] rq, input logic [2:0] up,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    int prev, w;
    if (!r) begin
      m_owner = -1; m_ten = 0; m_ptr = 0; m_show = '0; m_since = 0;
    end else begin
      prev = m_owner;
      w    = -1;
      if (m_owner < 0) begin
        w = rr_pick(rq, m_ptr, -1);
      end else if (!rq[m_owner]) begin
        if (up[m_owner]) m_show = pick_word(m_owner, a, b, c);
        m_owner = -1;
      end else if (m_ten >= HOLD - 1) begin
        w = rr_pick(rq, m_ptr, m_owner);
        if (w < 0 && up[m_owner]) m_show = pick_word(m_owner, a, b, c);
      end else begin
        if (up[m_owner]) m_show = pick_word(m_owner, a, b, c);
        m_ten++;
      end
      if (w >= 0) begin
        m_owner = w;
        m_ten   = 0;
        m_show  = pick_word(w, a, b, c);
        m_ptr   = (w + 1) % 3;
      end
      if (m_owner != prev) m_since = 0;
      else if (m_owner >= 0) m_since++;
    end
  endtask

  task automatic compare_all();
    logic [2:0] eg;
    logic [7:0] eb;
    eg = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
`ifdef DISP_BLINK_EN
    eb = (((m_since / BH) % 2) == 1) ? blink_mask : 8'h00;
`else
    eb = 8'h00;
`endif
    chk("gnt", 32'(gnt), 32'(eg));
    chk("show_data", show_data, m_show);
    chk("busy", 32'(busy), 32'(eg != 3'b000));
    chk("blank", 32'(blank), 32'(eb));
    chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
  endtask

  // Apply inputs for one clock, advance the model, check on the falling edge.
  task automatic cyc(input logic r, input logic [2:0] rq, input logic [2:0] up,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    rst = r; req = rq; upd = up; data0 = a; data1 = b; data2 = c;
    @(posedge clk);
    model_step(r, rq, up, a, b, c);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [2:0] rq;
    rst = 1'b0; req = '0; upd = '0; data0 = '0; data1 = '0; data2 = '0;
    blink_mask = 8'h0F;
    @(negedge clk);

    // Reset with all requests asserted.
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 3'b111, 3'b111, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_show", show_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end

    // Single requester 1 from idle.
    cyc(1'b1, 3'b010, 3'b000, 32'h0, 32'h1234ABCD, 32'h0);
    chk("first_gnt", 32'(gnt), 32'h2);
    chk("first_show", show_data, 32'h1234ABCD);
    cyc(1'b1, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0);
    chk("release_gnt", 32'(gnt), 32'h0);
    chk("release_show", show_data, 32'h1234ABCD);

    // Owner 0 keeps the grant for exactly HOLD cycles against requester 1.
    cyc(1'b1, 3'b011, 3'b000, 32'hA, 32'hB, 32'hC);
    chk("hold_gnt0", 32'(gnt), 32'h1);
    for (int i = 1; i < HOLD; i++) begin
      cyc(1'b1, 3'b011, 3'b000, 32'hA, 32'hB, 32'hC);
      chk("hold_gnt", 32'(gnt), 32'h1);
    end
    cyc(1'b1, 3'b011, 3'b000, 32'hA, 32'hB, 32'hC);
    chk("preempt_gnt", 32'(gnt), 32'h2);
    chk("preempt_show", show_data, 32'hB);

    // Owner 1 drops its request: one idle cycle, then requester 0.
    cyc(1'b1, 3'b011, 3'b000, 32'hA, 32'hB, 32'hC);
    cyc(1'b1, 3'b001, 3'b000, 32'hA, 32'hB, 32'hC);
    chk("drop_idle", 32'(gnt), 32'h0);
    cyc(1'b1, 3'b001, 3'b000, 32'hA, 32'hB, 32'hC);
    chk("drop_regrant", 32'(gnt), 32'h1);

    // Owner 2 updates; requester 0 strobe is ignored.
    cyc(1'b1, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0);
    cyc(1'b1, 3'b100, 3'b000, 32'h0, 32'h0, 32'h1111_1111);
    chk("own2_gnt", 32'(gnt), 32'h4);
    chk("own2_show", show_data, 32'h1111_1111);
    cyc(1'b1, 3'b100, 3'b101, 32'hDEAD0000, 32'h0, 32'h00000055);
    chk("upd_owner", show_data, 32'h00000055);
    cyc(1'b1, 3'b101, 3'b001, 32'hCAFE_F00D, 32'h0, 32'h00000055);
    chk("upd_nonowner", show_data, 32'h00000055);
    cyc(1'b1, 3'b101, 3'b000, 32'hCAFE_F00D, 32'h0, 32'h00000055);
    // Handover edge: owner's update is dropped in favour of the new owner's word.
    cyc(1'b1, 3'b101, 3'b100, 32'hA0A0_A0A0, 32'h0, 32'hBBBB_BBBB);
    chk("handover_gnt", 32'(gnt), 32'h1);
    chk("handover_show", show_data, 32'hA0A0_A0A0);

    // Random traffic; requests change only occasionally so HOLD is reached.
    rq = 3'b000;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 3) == 0) rq = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) blink_mask = 8'($urandom);
      cyc(($urandom_range(0, 59) != 0), rq, 3'($urandom_range(0, 7) & $urandom_range(0, 7)),
          $urandom, $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
- REQ-001: Parameters SHALL be, one per line:
  - HOLD_CYCLES, 100000000, minimum grant tenure in clk cycles before preemption (1 s at 100 MHz).
  - BLINK_HALF, 25000000, blink half-period in clk cycles (used only with DISP_BLINK_EN).
- REQ-002: Ports SHALL be, one per line:
  - clk  in  1  100 MHz system clock.
  - rst  in  1  reset, synchronous, active-low.
  - req  in  3  per-requester display request (0=CPU MMIO, 1=PC debug, 2=switch echo), level.
  - upd  in  3  per-requester single-cycle update strobe.
  - data0  in  32  requester 0 display word.
  - data1  in  32  requester 1 display word.
  - data2  in  32  requester 2 display word.
  - blink_mask  in  8  digits to blink, bit k = digit k (DISP_BLINK_EN only).
  - gnt  out  3  one-hot grant; all-zero when idle.
  - show_data  out  32  word for the tube driver.
  - blank  out  8  per-digit blank to the tube driver, 1 = digit off.
  - busy  out  1  high while any grant is held.

Function
- REQ-003: FSM SHALL have states IDLE, GRANT, HOLD.
- REQ-004: IDLE with any req high SHALL select a winner by round-robin from pointer ptr, then go to GRANT at the next edge.
  - On that same edge: gnt = one-hot(winner), show_data = that requester's data, hold counter = 0.
- REQ-005: Round-robin search order SHALL be ptr, ptr+1, ptr+2 (mod 3).
  - ptr SHALL become winner+1 (mod 3) on every grant.
- REQ-006: In GRANT, the hold counter SHALL increment each cycle.
  - On reaching HOLD_CYCLES-1, FSM SHALL go to HOLD; the counter saturates.
- REQ-007: In GRANT or HOLD, if the owner's req is low, gnt SHALL clear and FSM SHALL go to IDLE at the next edge.
  - show_data SHALL retain its last value.
- REQ-008: In HOLD, if owner req is high and another req is high, grant SHALL move to the round-robin winner among the other requesters at the next edge, as in REQ-004.
- REQ-009: In HOLD with no competing req, owner SHALL keep the grant indefinitely.
- REQ-010: upd[i] with gnt[i]=1 SHALL load data_i into show_data at the next edge (1-cycle latency).
  - upd from non-owners SHALL be ignored.
- REQ-011: upd[owner] on the same edge as a handover SHALL be dropped; the new owner's data wins.
- REQ-012: busy SHALL equal |gnt, registered.
- REQ-013: gnt SHALL never have more than one bit set.

Reset
- REQ-014: rst=0 at a clk edge SHALL force, regardless of state:
  - FSM = IDLE, gnt = 0, show_data = 32'h0, blank = 8'h00, busy = 0, ptr = 0, hold counter = 0, blink counter = 0.

Configuration
- REQ-015: Macro DISP_BLINK_EN SHALL gate the blink feature.
  - Defined: a blink phase bit SHALL toggle every BLINK_HALF cycles while busy, and blank = blink_mask & {8{phase}}.
  - Defined: phase SHALL reset to 0 on each grant change.
  - Undefined: blink_mask is ignored, blank is constant 8'h00, and no blink counter logic exists.

Structure
- REQ-016: Package disp_arb_pkg SHALL hold:
  - the state enum (IDLE/GRANT/HOLD);
  - N_REQ = 3;
  - requester index constants REQ_CPU = 0, REQ_PC = 1, REQ_SW = 2.
- REQ-017: Sub-module disp_rr_pick SHALL be combinational.
  - Inputs: req vector, ptr, exclude mask.
  - Outputs: winner index and valid.

Verification (HOLD_CYCLES=4, BLINK_HALF=2)
- REQ-018: rst=0 for 2 cycles with req=3'b111 -> gnt=0, show_data=0, busy=0 throughout.
- REQ-019: From idle, req=3'b010, data1=32'h1234ABCD -> gnt=3'b010 and show_data=32'h1234ABCD one cycle later.
- REQ-020: Owner 0 holds and req=3'b011 -> gnt stays 3'b001 for exactly 4 cycles, then becomes 3'b010.
- REQ-021: Owner 2, upd=3'b101, data0=32'hDEAD0000, data2=32'h00000055 -> show_data=32'h00000055 next cycle.
- REQ-022: Owner 1 drops req after 2 cycles while req[0]=1 -> gnt 3'b000 for one cycle (IDLE), then 3'b001.
- REQ-023: With DISP_BLINK_EN, blink_mask=8'h0F, busy -> blank alternates 8'h00/8'h0F every 2 cycles; without the macro, blank stays 8'h00.
